// File: rtl/req_encoder_pkg.sv
// req_encoder_pkg: shared constants and helpers for the request encoder
package req_encoder_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR = 1;
  localparam int N_MIN = 2;
  localparam int N_MAX = 256;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/req_encoder_prio_pick.sv
// prio_pick: first set bit of vec searching descending from start, wrapping N-1 after 0
module prio_pick #(
  parameter int N = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] j;
  // walk all N positions from start downward; the first hit wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = IDX_W'(int'(start) >= i ? int'(start) - i : int'(start) + N - i);
      if (!found && vec[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/req_encoder.sv
// req_encoder: captures request lines into a pending set and issues indices over valid/ready
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int MODE = MODE_FIXED,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             dup
);
  logic [IDX_W-1:0] last, start, sel;
  logic found, load, issue;
  logic [N-1:0] issue_mask;
  // round-robin resumes just below the last issued index; fixed priority always starts at the top
  assign start = (MODE == MODE_RR && last != '0) ? last - IDX_W'(1) : IDX_W'(N - 1);
  assign load = ~out_valid | out_ready;
  assign issue = load & found;
  assign issue_mask = issue ? {{(N-1){1'b0}}, 1'b1} << sel : '0;
  prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .vec(pending),
    .start(start),
    .found(found),
    .idx(sel)
  );
  // pending capture, merge detection, output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      dup <= 1'b0;
      out_valid <= 1'b0;
      out_idx <= '0;
      last <= '0;
    end else begin
      pending <= (pending & ~issue_mask) | req;
      dup <= |(req & pending & ~issue_mask);
      if (load) out_valid <= found;
      if (issue) begin
        out_idx <= sel;
        last <= sel;
      end
    end
  end
endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder: directed checks of fixed-priority, round-robin and non-power-of-two encoders
module tb_req_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic [7:0] req0 = '0, req1 = '0;
  logic [4:0] req2 = '0;
  logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic v0, v1, v2, d0, d1, d2;
  logic [2:0] i0, i1, i2;
  logic [7:0] p0, p1;
  logic [4:0] p2;

  req_encoder #(.N(8), .MODE(0)) u_fix (
    .clk(clk), .rst(rst0), .req(req0), .out_valid(v0), .out_ready(rdy0),
    .out_idx(i0), .pending(p0), .dup(d0));
  req_encoder #(.N(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst1), .req(req1), .out_valid(v1), .out_ready(rdy1),
    .out_idx(i1), .pending(p1), .dup(d1));
  req_encoder #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst(rst2), .req(req2), .out_valid(v2), .out_ready(rdy2),
    .out_idx(i2), .pending(p2), .dup(d2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    chk("rst valid", int'(v0), 0);
    chk("rst idx", int'(i0), 0);
    chk("rst pending", int'(p0), 0);
    chk("rst dup", int'(d0), 0);

    // single request
    req0 = 8'h04;
    tick();
    req0 = '0;
    chk("single pend", int'(p0), 8'h04);
    chk("single valid0", int'(v0), 0);
    tick();
    chk("single valid", int'(v0), 1);
    chk("single idx", int'(i0), 2);
    chk("single pend0", int'(p0), 0);
    tick();
    chk("single drop", int'(v0), 0);

    // fixed priority
    req0 = 8'h83;
    tick();
    req0 = '0;
    chk("fix pend", int'(p0), 8'h83);
    tick();
    chk("fix v7", int'(v0), 1);
    chk("fix i7", int'(i0), 7);
    chk("fix p7", int'(p0), 8'h03);
    tick();
    chk("fix i1", int'(i0), 1);
    tick();
    chk("fix i0", int'(i0), 0);
    chk("fix pend end", int'(p0), 0);
    tick();
    chk("fix idle", int'(v0), 0);
    chk("fix hold idx", int'(i0), 0);

    // request on the same edge its index issues stays pending
    req0 = 8'h01;
    tick();
    tick();
    req0 = '0;
    chk("same valid", int'(v0), 1);
    chk("same idx", int'(i0), 0);
    chk("same pend", int'(p0), 8'h01);
    chk("same dup", int'(d0), 0);
    tick();
    chk("same again", int'(v0), 1);
    tick();
    chk("same done", int'(v0), 0);

    // backpressure
    rdy0 = 1'b0;
    req0 = 8'h10;
    tick();
    req0 = '0;
    tick();
    chk("bp valid", int'(v0), 1);
    chk("bp idx", int'(i0), 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp stall idx", int'(i0), 4);
      chk("bp stall valid", int'(v0), 1);
    end
    req0 = 8'h10;
    tick();
    chk("bp repend", int'(p0), 8'h10);
    chk("bp nodup", int'(d0), 0);
    tick();
    req0 = '0;
    chk("bp dup", int'(d0), 1);
    chk("bp held", int'(i0), 4);
    tick();
    chk("bp dup clr", int'(d0), 0);
    rdy0 = 1'b1;
    tick();
    chk("bp 2nd valid", int'(v0), 1);
    chk("bp 2nd idx", int'(i0), 4);
    chk("bp 2nd pend", int'(p0), 0);
    tick();
    chk("bp end", int'(v0), 0);

    // reset mid-stall
    rdy0 = 1'b0;
    req0 = 8'h80;
    tick();
    req0 = '0;
    tick();
    req0 = 8'hF0;
    tick();
    chk("rs pend", int'(p0), 8'hF0);
    chk("rs valid", int'(v0), 1);
    req0 = 8'h0F;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    req0 = '0;
    chk("rs valid0", int'(v0), 0);
    chk("rs pend0", int'(p0), 0);
    chk("rs dup0", int'(d0), 0);
    chk("rs idx0", int'(i0), 0);
    tick();
    chk("rs nocap", int'(p0), 0);
    chk("rs still idle", int'(v0), 0);
    rdy0 = 1'b1;

    // round-robin, N=8
    req1 = 8'h83;
    tick();
    chk("rr valid0", int'(v1), 0);
    begin
      int exp_seq[6] = '{7, 1, 0, 7, 1, 0};
      foreach (exp_seq[k]) begin
        tick();
        chk("rr valid", int'(v1), 1);
        chk("rr idx", int'(i1), exp_seq[k]);
      end
    end
    tick();
    tick();
    chk("rr idx b", int'(i1), 1);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("rr rst valid", int'(v1), 0);
    chk("rr rst pend", int'(p1), 0);
    tick();
    chk("rr post pend", int'(p1), 8'h83);
    tick();
    chk("rr ptr reset", int'(i1), 7);
    req1 = '0;

    // round-robin, N=5
    req2 = 5'b10001;
    tick();
    begin
      int exp5[4] = '{4, 0, 4, 0};
      foreach (exp5[k]) begin
        tick();
        chk("n5 valid", int'(v2), 1);
        chk("n5 idx", int'(i2), exp5[k]);
        chk("n5 range", int'(i2 <= 3'd4), 1);
      end
    end
    req2 = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
